// File: rtl/bcd_to_binary_seq_pkg.sv
// Shared defaults, FSM encoding and helpers for the sequential BCD-to-binary converter.
package bcd_to_binary_seq_pkg;

  localparam int unsigned NdigDef = 3;
  localparam int unsigned BinWDef = 10;

  localparam int unsigned StateW = 2;
  localparam logic [StateW-1:0] StIdle  = 2'd0;
  localparam logic [StateW-1:0] StShift = 2'd1;
  localparam logic [StateW-1:0] StDone  = 2'd2;

  // Width of the shift counter for a given result width.
  function automatic int unsigned cnt_width(input int unsigned bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_nibble_adj.sv
// One BCD digit correction step of reverse double-dabble: subtract 3 when the nibble is >= 8.
module bcd_nibble_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? (din - 4'd3) : din;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter, one shift-right/subtract-3 step per clock,
// with a start/done handshake and illegal-digit flag.
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int unsigned NDIG  = NdigDef,
  parameter int unsigned BIN_W = BinWDef
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BIN_W-1:0]  bin_out
);

  localparam int unsigned BcdW  = 4 * NDIG;
  localparam int unsigned WorkW = BcdW + BIN_W;
  localparam int unsigned CntW  = cnt_width(BIN_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);

  if ((2 ** BIN_W) < (10 ** NDIG)) begin : g_bad_width
    $error("BIN_W too small to hold 10**NDIG - 1");
  end

  logic [StateW-1:0] state_q, state_d;
  logic [WorkW-1:0]  work_q, work_d;
  logic [WorkW-1:0]  work_shr, work_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              err_pend_q, err_pend_d;
  logic              bcd_ok;

  always_comb begin
    bcd_ok = 1'b1;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
    end
  end

  assign work_shr = work_q >> 1;
  assign work_adj[BIN_W-1:0] = work_shr[BIN_W-1:0];

  for (genvar g = 0; g < int'(NDIG); g++) begin : g_adj
    bcd_nibble_adj u_adj (
      .din  (work_shr[BIN_W+4*g +: 4]),
      .dout (work_adj[BIN_W+4*g +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    err_d      = err_q;
    err_pend_d = err_pend_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          if (bcd_ok) begin
            work_d     = {bcd_in, {BIN_W{1'b0}}};
            cnt_d      = '0;
            err_pend_d = 1'b0;
          end else begin
            // Illegal input: one busy cycle with no shifting, then report err with result 0.
            work_d     = '0;
            cnt_d      = LastCnt;
            err_pend_d = 1'b1;
          end
        end
      end
      StShift: begin
        if (!err_pend_q) work_d = work_adj;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          bin_d   = err_pend_q ? '0 : work_adj[BIN_W-1:0];
          err_d   = err_pend_q;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      work_q     <= '0;
      cnt_q      <= '0;
      bin_q      <= '0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign ready   = (state_q == StIdle);
  assign busy    = (state_q == StShift);
  assign done    = (state_q == StDone);
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: latency, handshake, illegal digits, reset and a full sweep.
module tb_bcd_to_binary_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  bin_out;

  int tests;
  int fails;

  bcd_to_binary_seq #(
    .NDIG  (3),
    .BIN_W (10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .bin_out (bin_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, pulses start with bcd, returns result and edges from accept to done.
  task automatic convert(input logic [11:0] bcd, output logic [9:0] bin, output logic e,
                         output int lat);
    int w;
    for (w = 0; w < 20 && !ready; w++) step();
    if (!ready) begin
      tests++; fails++;
      $display("FAIL convert_ready: ready=%0b required 1", ready);
    end
    start  = 1'b1;
    bcd_in = bcd;
    step();
    start = 1'b0;
    for (lat = 0; lat < 40 && !done; lat++) step();
    if (!done) begin
      tests++; fails++;
      $display("FAIL convert_timeout: done never rose for bcd %03h", bcd);
    end
    bin = bin_out;
    e   = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    tests++;
    if ({ready, busy, done, err, bin_out} !== {1'b1, 1'b1 ^ 1'b1, 1'b0, 1'b0, 10'd0}) begin
      fails++;
      $display("FAIL reset_state: rdy=%0b busy=%0b done=%0b err=%0b bin=%0d required 1 0 0 0 0",
               ready, busy, done, err, bin_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    logic [9:0] b; logic e; int lat;
    convert(12'h000, b, e, lat);
    tests++;
    if (lat !== 10) begin fails++; $display("FAIL zero_latency: %0d required 10", lat); end
    tests++;
    if (b !== 10'd0 || e !== 1'b0) begin
      fails++; $display("FAIL zero_result: bin=%0d err=%0b required 0 0", b, e);
    end
    tests++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      fails++; $display("FAIL zero_done_flags: busy=%0b ready=%0b required 0 0", busy, ready);
    end
    step();
    tests++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL zero_ready_after: ready=%0b done=%0b required 1 0", ready, done);
    end
  endtask

  task automatic test_basic();
    logic [9:0] b; logic e; int lat;
    convert(12'h255, b, e, lat);
    tests++;
    if (lat !== 10) begin fails++; $display("FAIL b255_latency: %0d required 10", lat); end
    tests++;
    if (b !== 10'h0FF || e !== 1'b0) begin
      fails++; $display("FAIL b255_result: bin=%0d err=%0b required 255 0", b, e);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int gap;
    start  = 1'b1;
    bcd_in = 12'h999;
    for (int w = 0; w < 20 && !ready; w++) step();
    step();
    for (lat = 0; lat < 40 && !done; lat++) step();
    tests++;
    if (lat !== 10 || bin_out !== 10'd999) begin
      fails++; $display("FAIL b2b_first: lat=%0d bin=%0d required 10 999", lat, bin_out);
    end
    bcd_in = 12'h100;
    step();
    for (gap = 1; gap < 40 && !done; gap++) begin
      if (gap == 6) begin
        tests++;
        if (bin_out !== 10'd999 || busy !== 1'b1) begin
          fails++; $display("FAIL b2b_hold: bin=%0d busy=%0b required 999 1", bin_out, busy);
        end
      end
      step();
    end
    start = 1'b0;
    tests++;
    if (gap !== 12 || bin_out !== 10'd100) begin
      fails++; $display("FAIL b2b_second: period=%0d bin=%0d required 12 100", gap, bin_out);
    end
  endtask

  task automatic test_illegal();
    logic [9:0] b; logic e; int lat;
    convert(12'h1A3, b, e, lat);
    tests++;
    if (lat !== 1 || e !== 1'b1 || b !== 10'd0) begin
      fails++; $display("FAIL illegal_1a3: lat=%0d err=%0b bin=%0d required 1 1 0", lat, e, b);
    end
    convert(12'h042, b, e, lat);
    tests++;
    if (lat !== 10 || e !== 1'b0 || b !== 10'd42) begin
      fails++; $display("FAIL after_illegal_042: lat=%0d err=%0b bin=%0d required 10 0 42",
                        lat, e, b);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    start  = 1'b1;
    bcd_in = 12'h123;
    for (int w = 0; w < 20 && !ready; w++) step();
    step();
    start = 1'b0;
    for (lat = 0; lat < 40 && !done; lat++) begin
      if (lat == 3) begin start = 1'b1; bcd_in = 12'h999; end
      if (lat == 4) start = 1'b0;
      if (lat == 6) bcd_in = 12'h777;
      step();
    end
    tests++;
    if (lat !== 10 || bin_out !== 10'd123 || err !== 1'b0) begin
      fails++; $display("FAIL ignore_start: lat=%0d bin=%0d err=%0b required 10 123 0",
                        lat, bin_out, err);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] b; logic e; int lat;
    int saw_done;
    start  = 1'b1;
    bcd_in = 12'h555;
    for (int w = 0; w < 20 && !ready; w++) step();
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ready, busy, done, err, bin_out} !== {1'b1, 1'b0, 1'b0, 1'b0, 10'd0}) begin
      fails++;
      $display("FAIL reset_mid: rdy=%0b busy=%0b done=%0b err=%0b bin=%0d required 1 0 0 0 0",
               ready, busy, done, err, bin_out);
    end
    saw_done = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || !ready) saw_done++;
    end
    tests++;
    if (saw_done !== 0) begin
      fails++; $display("FAIL reset_mid_quiet: %0d active cycles required 0", saw_done);
    end
    convert(12'h555, b, e, lat);
    tests++;
    if (b !== 10'd555 || e !== 1'b0) begin
      fails++; $display("FAIL reset_mid_555: bin=%0d err=%0b required 555 0", b, e);
    end
  endtask

  task automatic test_sweep();
    logic [9:0]  b; logic e; int lat;
    logic [11:0] v;
    for (int n = 0; n < 1000; n++) begin
      v = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
      convert(v, b, e, lat);
      tests++;
      if (b !== 10'(n) || e !== 1'b0 || lat !== 10) begin
        fails++; $display("FAIL sweep_%03h: bin=%0d err=%0b lat=%0d required %0d 0 10",
                          v, b, e, lat, n);
      end
    end
    for (int p = 0; p < 3; p++) begin
      for (int d = 10; d < 16; d++) begin
        v = 12'h555;
        v[4*p +: 4] = 4'(d);
        convert(v, b, e, lat);
        tests++;
        if (b !== 10'd0 || e !== 1'b1 || lat !== 1) begin
          fails++; $display("FAIL illegal_%03h: bin=%0d err=%0b lat=%0d required 0 1 1",
                            v, b, e, lat);
        end
      end
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    test_reset();
    test_zero();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_ignore_start();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
